// File: rtl/uart_rx_cfg_if.sv
// Received-word bus of the configurable UART receiver: one word plus its
// error flags, qualified by a single-cycle o_rx_dv strobe.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 o_rx_dv;
    logic [DATA_BITS-1:0] o_rx_data;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_break;

    // Receiver drives the word and flags
    modport master (
        output o_rx_dv,
        output o_rx_data,
        output o_parity_err,
        output o_frame_err,
        output o_break
    );

    // Packet parser consumes them
    modport slave (
        input o_rx_dv,
        input o_rx_data,
        input o_parity_err,
        input o_frame_err,
        input o_break
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime clocks-per-bit, none/even/odd parity,
// one or two stop bits, 3-sample majority per bit, parity/framing/break flags.
module uart_rx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx_serial,
    input  logic [DIV_WIDTH-1:0] i_clks_per_bit,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
    uart_rx_cfg_if.master        rx_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t state, state_n;

    logic                 rx_meta, rx_s;
    logic [DIV_WIDTH-1:0] d_l, cnt;
    logic [DIV_WIDTH-1:0] h_c, h_m1, h_p1, d_m1;
    logic                 par_en_l, par_odd_l, two_stop_l;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 samp_a, samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, any_one, par_err_r, stop_bad;

    logic                 at_hm1, at_h, decide, wrap, maj;
    logic                 final_stop, frame_now, brk_now;
    logic                 start_det, shift_en, par_dec, stop_dec, emit;
    logic [DIV_WIDTH-1:0] d_in;

    // Two-flop synchronizer for the asynchronous RX pin, idling high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_serial;
            rx_s    <= rx_meta;
        end
    end

    // Divisor clamp and the derived sample/wrap points of the latched divisor
    always_comb begin
        d_in   = (i_clks_per_bit < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : i_clks_per_bit;
        h_c    = d_l >> 1;
        h_m1   = h_c - DIV_WIDTH'(1);
        h_p1   = h_c + DIV_WIDTH'(1);
        d_m1   = d_l - DIV_WIDTH'(1);
        at_hm1 = (cnt == h_m1);
        at_h   = (cnt == h_c);
        decide = (cnt == h_p1);
        wrap   = (cnt == d_m1);
        // third sample is the live synchronized line at the decision point
        maj        = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
        final_stop = stop_idx | ~two_stop_l;
        frame_now  = stop_bad | ~maj;
        brk_now    = frame_now & ~any_one;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     if (!rx_s) state_n = S_START;
            S_START: begin
                if (decide && maj) state_n = S_IDLE;
                else if (wrap)     state_n = S_DATA;
            end
            S_DATA:     if (wrap && bit_idx == LAST_BIT) state_n = par_en_l ? S_PARITY : S_STOP;
            S_PARITY:   if (wrap) state_n = S_STOP;
            // leave on the final stop decision; the rest of the stop bit is not waited out
            S_STOP:     if (decide && final_stop) state_n = brk_now ? S_BRK_WAIT : S_IDLE;
            S_BRK_WAIT: if (rx_s) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath
    always_comb begin
        start_det = 1'b0;
        shift_en  = 1'b0;
        par_dec   = 1'b0;
        stop_dec  = 1'b0;
        emit      = 1'b0;
        unique case (state)
            S_IDLE:   start_det = ~rx_s;
            S_DATA:   shift_en  = decide;
            S_PARITY: par_dec   = decide;
            S_STOP: begin
                stop_dec = decide;
                emit     = decide & final_stop;
            end
            default: ;
        endcase
    end

    // Bit timing, sampling, shifting and error accumulation for the frame in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            d_l        <= DIV_WIDTH'(4);
            par_en_l   <= 1'b0;
            par_odd_l  <= 1'b0;
            two_stop_l <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            shreg      <= '0;
            par_acc    <= 1'b0;
            any_one    <= 1'b0;
            par_err_r  <= 1'b0;
            stop_bad   <= 1'b0;
        end else begin
            if (start_det) begin
                // the detect cycle itself is offset 0 of the start bit
                d_l        <= d_in;
                par_en_l   <= ^i_parity_mode;
                par_odd_l  <= i_parity_mode[1];
                two_stop_l <= i_two_stop;
                cnt        <= DIV_WIDTH'(1);
                bit_idx    <= '0;
                stop_idx   <= 1'b0;
                par_acc    <= 1'b0;
                any_one    <= 1'b0;
                par_err_r  <= 1'b0;
                stop_bad   <= 1'b0;
            end else if (state != S_IDLE && state != S_BRK_WAIT) begin
                cnt <= wrap ? '0 : cnt + DIV_WIDTH'(1);
            end

            if (at_hm1) samp_a <= rx_s;
            if (at_h)   samp_b <= rx_s;

            if (shift_en) begin
                shreg   <= {maj, shreg[DATA_BITS-1:1]};
                par_acc <= par_acc ^ maj;
                any_one <= any_one | maj;
            end
            if (state == S_DATA && wrap) bit_idx <= bit_idx + 4'd1;

            if (par_dec) begin
                par_err_r <= (par_acc ^ maj) != par_odd_l;
                any_one   <= any_one | maj;
            end

            if (stop_dec) stop_bad <= stop_bad | ~maj;
            if (state == S_STOP && wrap) stop_idx <= 1'b1;
        end
    end

    // Registered word/flags, updated only with the o_rx_dv strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_out.o_rx_dv      <= 1'b0;
            rx_out.o_rx_data    <= '0;
            rx_out.o_parity_err <= 1'b0;
            rx_out.o_frame_err  <= 1'b0;
            rx_out.o_break      <= 1'b0;
        end else begin
            rx_out.o_rx_dv <= emit;
            if (emit) begin
                rx_out.o_rx_data    <= brk_now ? '0 : shreg;
                rx_out.o_parity_err <= par_err_r;
                rx_out.o_frame_err  <= frame_now;
                rx_out.o_break      <= brk_now;
            end
        end
    end

endmodule
